vga_sync_decoder: RTL and testbench



---
 rtl/vga_sync_decoder_pkg.sv | 37 +++
 rtl/vga_sync_decoder_sync_edge.sv | 24 ++
 rtl/vga_sync_decoder.sv | 161 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA timing defaults, decoder FSM encoding and sync helpers.
// Defaults match the 640x480@60Hz timing generator.
package vga_sync_decoder_pkg;

  localparam int H_VISIBLE_DEF     = 640;
  localparam int H_FRONT_PORCH_DEF = 16;
  localparam int H_SYNC_PULSE_DEF  = 96;
  localparam int H_WHOLE_LINE_DEF  = 800;
  localparam int V_VISIBLE_DEF     = 480;
  localparam int V_FRONT_PORCH_DEF = 10;
  localparam int V_SYNC_PULSE_DEF  = 2;
  localparam int V_WHOLE_FRAME_DEF = 525;
  localparam int LOCK_FRAMES_DEF   = 2;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  function automatic int sync_start(
    input int vis,
    input int fp
  );
    return vis + fp;
  endfunction

  function automatic int sync_end(
    input int vis,
    input int fp,
    input int pulse
  );
    return vis + fp + pulse;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge.sv
// One-bit sync sampler; compares the new sample with the registered one.
// Idles high so reset release never reports a phantom falling edge.
module vga_sync_decoder_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_fall,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b1;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_fall = r_q & ~i_d;
  assign o_rise = ~r_q & i_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds column/row/visible from active-low hsync/vsync and
// tracks timing lock with a SEARCH/ALIGN/VERIFY/LOCKED FSM.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int H_VISIBLE     = H_VISIBLE_DEF,
  parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
  parameter int H_SYNC_PULSE  = H_SYNC_PULSE_DEF,
  parameter int H_WHOLE_LINE  = H_WHOLE_LINE_DEF,
  parameter int V_VISIBLE     = V_VISIBLE_DEF,
  parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
  parameter int V_SYNC_PULSE  = V_SYNC_PULSE_DEF,
  parameter int V_WHOLE_FRAME = V_WHOLE_FRAME_DEF,
  parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic       visible,
  output logic       locked,
  output logic       sync_error
);

  localparam logic [9:0] HSS = 10'(sync_start(
    H_VISIBLE, H_FRONT_PORCH));
  localparam logic [9:0] HSE = 10'(sync_end(
    H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE));
  localparam logic [9:0] VSS = 10'(sync_start(
    V_VISIBLE, V_FRONT_PORCH));
  localparam logic [9:0] VSE = 10'(sync_end(
    V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE));
  localparam logic [9:0] H_LAST = 10'(H_WHOLE_LINE - 1);
  localparam logic [9:0] V_LAST = 10'(V_WHOLE_FRAME - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t     r_state;
  logic [9:0] r_col;
  logic [9:0] r_row;
  logic [3:0] r_clean;
  logic       r_locked;
  logic       r_err;

  logic       w_hfall;
  logic       w_hrise;
  logic       w_vfall;
  logic       w_vrise;
  logic       w_wrap;
  logic       w_check;
  logic       w_err;
  logic [9:0] w_pcol;
  logic [9:0] w_prow;
  logic [9:0] w_ncol;
  logic [9:0] w_nrow;
  logic [3:0] w_clean_nx;

  vga_sync_decoder_sync_edge u_hedge (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (hsync),
    .o_fall (w_hfall),
    .o_rise (w_hrise)
  );

  vga_sync_decoder_sync_edge u_vedge (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (vsync),
    .o_fall (w_vfall),
    .o_rise (w_vrise)
  );

  // Predicted position of the incoming sample, before any forcing.
  always_comb begin
    w_wrap = (r_col == H_LAST);
    w_pcol = w_wrap ? '0 : r_col + 10'd1;
    w_prow = r_row;
    if (w_wrap) begin
      w_prow = (r_row == V_LAST) ? '0 : r_row + 10'd1;
    end
  end

  always_comb begin
    w_check = (r_state == ST_VERIFY) ||
              (r_state == ST_LOCKED);
    w_err   = 1'b0;
    if (w_check) begin
      w_err = (w_hfall && (w_vfall || w_pcol != HSS)) ||
              (w_hrise && w_pcol != HSE) ||
              (w_vfall && (w_prow != VSS || w_pcol != '0)) ||
              (w_vrise && (w_prow != VSE || w_pcol != '0));
    end
  end

  always_comb begin
    w_ncol = w_pcol;
    w_nrow = w_prow;
    if (r_state == ST_SEARCH) begin
      w_ncol = w_hfall ? HSS : '0;
      w_nrow = '0;
    end else if (w_vfall) begin
      w_ncol = '0;
      w_nrow = VSS;
    end else if (w_hfall) begin
      w_ncol = HSS;
    end
  end

  assign w_clean_nx = r_clean + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_SEARCH;
      r_col    <= '0;
      r_row    <= '0;
      r_clean  <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_col    <= w_ncol;
      r_row    <= w_nrow;
      r_err    <= w_err;
      r_locked <= (r_state == ST_LOCKED);
      unique case (r_state)
        ST_SEARCH: begin
          if (w_hfall) r_state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          if (w_vfall) begin
            r_state <= ST_VERIFY;
            r_clean <= '0;
          end
        end
        ST_VERIFY: begin
          if (w_err) begin
            r_state <= ST_ALIGN;
          end else if (w_vfall) begin
            r_clean <= w_clean_nx;
            if (w_clean_nx == LOCK_N) r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_err) r_state <= ST_ALIGN;
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  assign column     = r_col;
  assign row        = r_row;
  assign locked     = r_locked;
  assign sync_error = r_err;
  assign visible    = r_locked && (r_col < H_VIS) &&
                      (r_row < V_VIS);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 36x14 raster.
// A second instance is built with LOCK_FRAMES=1.
module tb_vga_sync_decoder;

  localparam int HV  = 16;
  localparam int HFP = 4;
  localparam int HSP = 8;
  localparam int HW  = 36;
  localparam int VV  = 8;
  localparam int VFP = 2;
  localparam int VSP = 2;
  localparam int VW  = 14;
  localparam int HSS = 20;
  localparam int HSE = 28;
  localparam int VSS = 10;
  localparam int VSE = 12;
  localparam int FRAME = HW * VW;

  logic       clk;
  logic       rst_n;
  logic       hsync;
  logic       vsync;
  logic [9:0] column0, row0, column1, row1;
  logic       visible0, locked0, err0;
  logic       visible1, locked1, err1;

  int n_checks;
  int n_fail;
  int gcol, grow, pcol, prow;
  int line_len;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT_PORCH(HFP),
    .H_SYNC_PULSE(HSP), .H_WHOLE_LINE(HW),
    .V_VISIBLE(VV), .V_FRONT_PORCH(VFP),
    .V_SYNC_PULSE(VSP), .V_WHOLE_FRAME(VW),
    .LOCK_FRAMES(2)
  ) dut0 (
    .clk(clk), .reset(rst_n),
    .hsync(hsync), .vsync(vsync),
    .column(column0), .row(row0),
    .visible(visible0), .locked(locked0),
    .sync_error(err0)
  );

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT_PORCH(HFP),
    .H_SYNC_PULSE(HSP), .H_WHOLE_LINE(HW),
    .V_VISIBLE(VV), .V_FRONT_PORCH(VFP),
    .V_SYNC_PULSE(VSP), .V_WHOLE_FRAME(VW),
    .LOCK_FRAMES(1)
  ) dut1 (
    .clk(clk), .reset(rst_n),
    .hsync(hsync), .vsync(vsync),
    .column(column1), .row(row1),
    .visible(visible1), .locked(locked1),
    .sync_error(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic hs_nom();
    return !(gcol >= HSS && gcol < HSE);
  endfunction

  function automatic logic vs_nom();
    return !(grow >= VSS && grow < VSE);
  endfunction

  task automatic step(input logic hs, input logic vs);
    hsync = hs;
    vsync = vs;
    pcol  = gcol;
    prow  = grow;
    @(posedge clk);
    #1;
    gcol = gcol + 1;
    if (gcol >= line_len) begin
      gcol = 0;
      grow = (grow == VW - 1) ? 0 : grow + 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(hs_nom(), vs_nom());
  endtask

  task automatic run_to(input int c, input int r);
    int  k;
    bit  hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < 2 * FRAME) begin
      hit = (gcol == c && grow == r);
      step(hs_nom(), vs_nom());
      k++;
    end
    if (!hit) begin
      n_fail++;
      $display("FAIL run_to: position %0d,%0d not reached", c, r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (column0 !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_column: got %0d want 0", column0);
    end
    n_checks++;
    if (row0 !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_row: got %0d want 0", row0);
    end
    n_checks++;
    if ({visible0, locked0, err0} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {visible0, locked0, err0});
    end
    n_checks++;
    if ({visible1, locked1, err1} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags1: got %b want 000",
               {visible1, locked1, err1});
    end
    rst_n = 1'b1;
    gcol  = 0;
    grow  = 0;
  endtask

  // vfall at sample 360; clean frames end at 864 and 1368.
  task automatic test_lock_acquire();
    run(865);
    n_checks++;
    if (locked1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lock1_early: got %b want 0", locked1);
    end
    run(1);
    n_checks++;
    if (locked1 !== 1'b1) begin
      n_fail++;
      $display("FAIL lock1_rise: got %b want 1", locked1);
    end
    run(503);
    n_checks++;
    if (locked0 !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: got %b want 0", locked0);
    end
    run(1);
    n_checks++;
    if (locked0 !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_rise: got %b want 1", locked0);
    end
  endtask

  task automatic test_loopback_track();
    logic exp_vis;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(hs_nom(), vs_nom());
      exp_vis = (pcol < HV) && (prow < VV);
      n_checks++;
      if (column0 !== 10'(pcol) || row0 !== 10'(prow)) begin
        n_fail++;
        $display("FAIL track_pos: got %0d,%0d want %0d,%0d",
                 column0, row0, pcol, prow);
      end
      n_checks++;
      if (visible0 !== exp_vis) begin
        n_fail++;
        $display("FAIL track_visible: got %b want %b at %0d,%0d",
                 visible0, exp_vis, pcol, prow);
      end
      n_checks++;
      if (err0 !== 1'b0 || locked0 !== 1'b1) begin
        n_fail++;
        $display("FAIL track_lock: err=%b locked=%b want 0/1",
                 err0, locked0);
      end
    end
  endtask

  task automatic relock_check(input string tag);
    run_to(0, VSS);
    n_checks++;
    if (locked0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_unlocked: got %b want 0", tag, locked0);
    end
    run(2 * FRAME);
    n_checks++;
    if (locked0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_relock_early: got %b want 0", tag, locked0);
    end
    run(1);
    n_checks++;
    if (locked0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_relock: got %b want 1", tag, locked0);
    end
  endtask

  task automatic test_hfall_delay();
    run_to(HW - 1, 2);
    for (int c = 0; c < HW; c++) begin
      step(!(gcol >= HSS + 3 && gcol < HSE), vs_nom());
      if (pcol == HSS + 2) begin
        n_checks++;
        if (err0 !== 1'b0) begin
          n_fail++;
          $display("FAIL hdelay_pre: err=%b want 0", err0);
        end
      end
      if (pcol == HSS + 3) begin
        n_checks++;
        if (err0 !== 1'b1 || column0 !== 10'(HSS) ||
            locked0 !== 1'b1) begin
          n_fail++;
          $display("FAIL hdelay_edge: err=%b col=%0d lk=%b want 1/%0d/1",
                   err0, column0, locked0, HSS);
        end
      end
      if (pcol == HSS + 4) begin
        n_checks++;
        if (locked0 !== 1'b0 || err0 !== 1'b0) begin
          n_fail++;
          $display("FAIL hdelay_drop: lk=%b err=%b want 0/0",
                   locked0, err0);
        end
      end
    end
    relock_check("hdelay");
  endtask

  task automatic test_short_hsync();
    run_to(HW - 1, 4);
    for (int c = 0; c < HW; c++) begin
      step(!(gcol >= HSS && gcol < HSE - 1), vs_nom());
      if (pcol == HSE - 2) begin
        n_checks++;
        if (err0 !== 1'b0) begin
          n_fail++;
          $display("FAIL hshort_pre: err=%b want 0", err0);
        end
      end
      if (pcol == HSE - 1) begin
        n_checks++;
        if (err0 !== 1'b1 || column0 !== 10'(HSE - 1)) begin
          n_fail++;
          $display("FAIL hshort_edge: err=%b col=%0d want 1/%0d",
                   err0, column0, HSE - 1);
        end
      end
      if (pcol == HSE) begin
        n_checks++;
        if (locked0 !== 1'b0) begin
          n_fail++;
          $display("FAIL hshort_drop: lk=%b want 0", locked0);
        end
      end
    end
    relock_check("hshort");
  endtask

  task automatic test_const_inputs();
    run_to(HW - 1, 0);
    for (int i = 0; i < 3 * HW; i++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (column0 !== 10'(pcol) || row0 !== 10'(prow) ||
          err0 !== 1'b0 || locked0 !== 1'b1) begin
        n_fail++;
        $display("FAIL const: pos %0d,%0d err=%b lk=%b want %0d,%0d 0 1",
                 column0, row0, err0, locked0, pcol, prow);
      end
    end
    run(HW);
    n_checks++;
    if (locked0 !== 1'b1) begin
      n_fail++;
      $display("FAIL const_resume: lk=%b want 1", locked0);
    end
  endtask

  task automatic test_reset_mid();
    run_to(5, 5);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({column0, row0, visible0, locked0, err0} !== 23'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: col=%0d row=%0d v=%b lk=%b e=%b want 0",
               column0, row0, visible0, locked0, err0);
    end
    for (int i = 0; i < 5; i++) begin
      step(hs_nom(), vs_nom());
      n_checks++;
      if ({column0, row0, visible0, locked0, err0,
           column1, row1, locked1} !== 31'd0) begin
        n_fail++;
        $display("FAIL rstmid_hold: col=%0d row=%0d lk=%b want 0",
                 column0, row0, locked0);
      end
    end
    rst_n = 1'b1;
    relock_check("rstmid");
  endtask

  // 35-cycle lines: first error while locked, then one per VERIFY.
  task automatic test_short_line();
    int pulses0;
    int pulses1;
    pulses0 = 0;
    pulses1 = 0;
    run_to(HW - 1, VW - 1);
    line_len = HW - 1;
    for (int i = 0; i < 3 * VW * (HW - 1); i++) begin
      step(hs_nom(), vs_nom());
      pulses0 += int'(err0);
      pulses1 += int'(err1);
    end
    n_checks++;
    if (pulses0 !== 4) begin
      n_fail++;
      $display("FAIL shortline_pulses: got %0d want 4", pulses0);
    end
    n_checks++;
    if (pulses1 !== 4) begin
      n_fail++;
      $display("FAIL shortline_pulses1: got %0d want 4", pulses1);
    end
    n_checks++;
    if (locked0 !== 1'b0 || locked1 !== 1'b0) begin
      n_fail++;
      $display("FAIL shortline_lock: got %b%b want 00",
               locked0, locked1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    line_len = HW;
    gcol     = 0;
    grow     = 0;
    test_reset();
    test_lock_acquire();
    test_loopback_track();
    test_hfall_delay();
    test_short_hsync();
    test_const_inputs();
    test_reset_mid();
    test_short_line();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
